bias_requant: RTL and testbench
===============================

Name: bias_requant

Overview:
- Post-accumulation stage directly downstream of the 8-word bias SRAM; consumes its 8-lane bias read port.
- Accepts one vector of 8 int32 partial sums plus a bias address from the PE array.
- Fetches 8 biases, adds them per lane, requantizes (scale, rounding shift, zero point, optional ReLU) and emits 8 int8 values to the output buffer.
- Non-pipelined FSM, one vector in flight.

Parameters:
- LANES, 8, lane count; fixed to match the bias SRAM read width.
- ADDR_W, 12, bias SRAM address width.
- ACC_W, 32, accumulator and bias width.
- SCALE_W, 16, unsigned requant multiplier width.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST  input  1  asynchronous, active-high reset.
- in_valid  input  1  accumulator vector valid.
- in_ready  output  1  block can accept a vector.
- in_acc  input  LANES*ACC_W  packed signed accumulators; lane i = bits [32i+31:32i].
- in_addr  input  ADDR_W  bias base address for this vector.
- cfg_scale  input  SCALE_W  unsigned multiplier.
- cfg_shift  input  5  right-shift amount, 0..31.
- cfg_zp  input  8  signed output zero point.
- cfg_relu  input  1  1 = clamp lower bound to cfg_zp.
- bias_addr  output  ADDR_W  bias SRAM address.
- bias_en  output  1  bias SRAM read enable.
- bias_do  input  [31:0] x [0:LANES-1]  bias SRAM read data (updated by the SRAM on negedge).
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  LANES*8  packed int8 results; lane i = bits [8i+7:8i].
- busy  output  1  state != IDLE.

Behaviour:
- Reset (async, RST=1): state=IDLE. in_ready=1 once RST deasserts. bias_en=0, bias_addr=0, out_valid=0, out_data=0, busy=0. All latched operands are cleared. A vector in flight when reset is asserted is dropped, with no output.
- in_ready = (state==IDLE); a combinational function of state only.
- States: IDLE -> FETCH -> ADD -> MUL -> QUANT -> OUT -> IDLE.
- IDLE: on in_valid&in_ready, latch in_acc, in_addr and all cfg_* values, then go to FETCH. cfg_* changes after acceptance have no effect on that vector.
- FETCH (1 cycle): bias_en=1, bias_addr=latched in_addr. The SRAM drives bias_do on the following negedge. bias_en=0 in every other state. bias_addr holds its last value outside FETCH.
- ADD: sample bias_do into registers. sum_i = sat32(acc_i + bias_i), computed in 33 bits and saturated to [-2^31, 2^31-1].
- MUL: prod_i = sum_i * {0,cfg_scale}, signed, 49-bit result.
- QUANT:
  - r_i = (prod_i + (shift>0 ? 1<<(shift-1) : 0)) >>> shift, arithmetic shift (round-half-up toward +inf).
  - v_i = r_i + zp.
  - lo = relu ? zp : -128, hi = 127; out_i = clamp(v_i, lo, hi).
  - Register out_data and set out_valid=1.
- OUT: hold out_valid=1 and out_data stable while out_ready=0. On out_ready=1, clear out_valid and go to IDLE. out_data keeps its last value.
- Latency: acceptance edge to out_valid rising = 4 cycles. Minimum throughput = 1 vector per 6 cycles; the next vector can be accepted the cycle after the OUT handshake.
- Address range: the caller guarantees in_addr <= 2^ADDR_W - LANES. The block performs no range check and no wrap.
- in_valid while busy: ignored and not latched. The upstream stage must hold in_valid until in_ready.

Test Plan:
- Basic: acc all 100, bias all -4, scale=3, shift=2, zp=0, relu=0 -> each lane 72 (96*3=288, (288+2)>>2=72); bias_en high exactly 1 cycle with bias_addr=in_addr; out_valid 4 cycles after accept.
- Clamp and rounding: lane0 acc=1000 bias=24 scale=1 shift=3 -> 127 (128 clamped); lane1 acc=-5 bias=0 shift=1 -> -2; lane2 acc=-2000 bias=0 shift=0 -> -128.
- Saturation: acc=0x7FFFFFF0, bias=0x100, scale=1, shift=24 -> sum saturates to 0x7FFFFFFF, result 128 -> clamped 127; same with a negative overflow -> -128.
- ReLU/zero point: acc=-50, bias=0, scale=1, shift=0, zp=5, relu=1 -> 5; with relu=0 -> -45; acc=200 with zp=5 -> 127.
- Backpressure: hold out_ready=0 for 10 cycles -> out_valid and out_data stable, in_ready=0, a second in_valid is not accepted; release -> handshake, then the second vector is accepted and has the correct result.
- Reset mid-operation: assert RST during MUL -> all outputs 0 immediately (async); after release in_ready=1, no stale out_valid, and the next vector processes correctly.

Source files
------------

// File: rtl/bias_requant.sv
// Adds 8 fetched biases to an accumulator vector, then scales, rounds, offsets and clamps each lane to int8.
// Accept-to-out_valid is 4 cycles with one vector in flight; the result holds in OUT until out_ready, with in_ready low.
module bias_requant #(
  parameter int LANES   = 8,
  parameter int ADDR_W  = 12,
  parameter int ACC_W   = 32,
  parameter int SCALE_W = 16
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*ACC_W-1:0]   in_acc,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [SCALE_W-1:0]       cfg_scale,
  input  logic [4:0]               cfg_shift,
  input  logic [7:0]               cfg_zp,
  input  logic                     cfg_relu,
  output logic [ADDR_W-1:0]        bias_addr,
  output logic                     bias_en,
  input  logic [ACC_W-1:0]         bias_do [0:LANES-1],
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*8-1:0]       out_data,
  output logic                     busy
);

  localparam int PROD_W = ACC_W + SCALE_W + 1;
  localparam int RND_W  = PROD_W + 1;

  typedef enum logic [2:0] {IDLE, FETCH, ADD, MUL, QUANT, OUT} state_t;

  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q  [LANES];
  logic signed [ACC_W-1:0]   acc_d  [LANES];
  logic signed [ACC_W-1:0]   sum_q  [LANES];
  logic signed [ACC_W-1:0]   sum_d  [LANES];
  logic signed [PROD_W-1:0]  prod_q [LANES];
  logic signed [PROD_W-1:0]  prod_d [LANES];
  logic [SCALE_W-1:0]        scale_q, scale_d;
  logic [4:0]                shift_q, shift_d;
  logic [7:0]                zp_q, zp_d;
  logic                      relu_q, relu_d;
  logic                      bias_en_q, bias_en_d;
  logic [ADDR_W-1:0]         bias_addr_q, bias_addr_d;
  logic                      out_valid_q, out_valid_d;
  logic [LANES*8-1:0]        out_data_q, out_data_d;

  function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                      input logic signed [ACC_W-1:0] b);
    logic signed [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    if (s[ACC_W] != s[ACC_W-1])
      sat_add = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      sat_add = s[ACC_W-1:0];
  endfunction

  // Scale is unsigned, so it is zero-extended before the signed multiply.
  function automatic logic signed [PROD_W-1:0] scale_mul(input logic signed [ACC_W-1:0] s,
                                                         input logic [SCALE_W-1:0] sc);
    logic signed [PROD_W-1:0] a, b;
    a = {{(PROD_W-ACC_W){s[ACC_W-1]}}, s};
    b = {{(PROD_W-SCALE_W){1'b0}}, sc};
    scale_mul = a * b;
  endfunction

  function automatic logic [7:0] requant(input logic signed [PROD_W-1:0] p,
                                         input logic [4:0] sh,
                                         input logic [7:0] zp,
                                         input logic relu);
    logic signed [RND_W-1:0] pe, rnd, r, v, lo, hi, zpe;
    pe  = {p[PROD_W-1], p};
    rnd = '0;
    if (sh != 5'd0) rnd = RND_W'(1) << (sh - 5'd1);
    r   = (pe + rnd) >>> sh;
    zpe = {{(RND_W-8){zp[7]}}, zp};
    v   = r + zpe;
    lo  = relu ? zpe : {{(RND_W-8){1'b1}}, 8'h80};
    hi  = RND_W'(127);
    if (v < lo)      v = lo;
    else if (v > hi) v = hi;
    requant = v[7:0];
  endfunction

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    prod_d      = prod_q;
    scale_d     = scale_q;
    shift_d     = shift_q;
    zp_d        = zp_q;
    relu_d      = relu_q;
    bias_en_d   = 1'b0;
    bias_addr_d = bias_addr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int i = 0; i < LANES; i++) acc_d[i] = in_acc[i*ACC_W +: ACC_W];
          scale_d     = cfg_scale;
          shift_d     = cfg_shift;
          zp_d        = cfg_zp;
          relu_d      = cfg_relu;
          bias_addr_d = in_addr;
          bias_en_d   = 1'b1;
          state_d     = FETCH;
        end
      end
      FETCH: state_d = ADD;
      ADD: begin
        for (int i = 0; i < LANES; i++) sum_d[i] = sat_add(acc_q[i], bias_do[i]);
        state_d = MUL;
      end
      MUL: begin
        for (int i = 0; i < LANES; i++) prod_d[i] = scale_mul(sum_q[i], scale_q);
        state_d = QUANT;
      end
      QUANT: begin
        for (int i = 0; i < LANES; i++)
          out_data_d[i*8 +: 8] = requant(prod_q[i], shift_q, zp_q, relu_q);
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      for (int i = 0; i < LANES; i++) begin
        acc_q[i]  <= '0;
        sum_q[i]  <= '0;
        prod_q[i] <= '0;
      end
      scale_q     <= '0;
      shift_q     <= '0;
      zp_q        <= '0;
      relu_q      <= 1'b0;
      bias_en_q   <= 1'b0;
      bias_addr_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      prod_q      <= prod_d;
      scale_q     <= scale_d;
      shift_q     <= shift_d;
      zp_q        <= zp_d;
      relu_q      <= relu_d;
      bias_en_q   <= bias_en_d;
      bias_addr_q <= bias_addr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign bias_en   = bias_en_q;
  assign bias_addr = bias_addr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_bias_requant.sv
// Randomized and directed bench for bias_requant against an arithmetic reference model and a bias SRAM model.
module tb_bias_requant;
  localparam int LANES = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [255:0] in_acc = '0;
  logic [11:0]  in_addr = '0;
  logic [15:0]  cfg_scale = '0;
  logic [4:0]   cfg_shift = '0;
  logic [7:0]   cfg_zp = '0;
  logic         cfg_relu = 1'b0;
  logic [11:0]  bias_addr;
  logic         bias_en;
  logic [31:0]  bias_do [0:LANES-1];
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [63:0]  out_data;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int mem [0:4095];

  bias_requant dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .in_acc(in_acc),
    .in_addr(in_addr), .cfg_scale(cfg_scale), .cfg_shift(cfg_shift), .cfg_zp(cfg_zp),
    .cfg_relu(cfg_relu), .bias_addr(bias_addr), .bias_en(bias_en), .bias_do(bias_do),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK)
    if (bias_en)
      for (int i = 0; i < LANES; i++) bias_do[i] <= mem[int'(bias_addr) + i];

  function automatic logic [7:0] ref_lane(input int acc, input int bias, input int sc,
                                          input int sh, input int zp, input bit relu);
    longint s, p, r, v, lo, mx, mn;
    mx = 64'sh7FFF_FFFF;
    mn = -mx - 1;
    s = longint'(acc) + longint'(bias);
    if (s > mx) s = mx;
    if (s < mn) s = mn;
    p = s * longint'(sc);
    if (sh > 0) p = p + (longint'(1) <<< (sh - 1));
    r = p >>> sh;
    v = r + longint'(zp);
    lo = relu ? longint'(zp) : -128;
    if (v < lo) v = lo;
    if (v > 127) v = 127;
    return 8'(v);
  endfunction

  function automatic logic [63:0] exp_vec(input logic [255:0] acc, input int addr, input logic [15:0] sc,
                                          input logic [4:0] sh, input logic [7:0] zp, input logic relu);
    logic [63:0] r;
    for (int i = 0; i < LANES; i++)
      r[8*i +: 8] = ref_lane(int'($signed(acc[32*i +: 32])), mem[addr + i], int'(sc), int'(sh),
                             int'($signed(zp)), relu);
    return r;
  endfunction

  // Drives one vector, scrambles inputs after acceptance, and waits for out_valid.
  task automatic run_vec(input logic [255:0] acc, input logic [11:0] addr, input logic [15:0] sc,
                         input logic [4:0] sh, input logic [7:0] zp, input logic relu,
                         output int lat, output int en_cnt, output bit addr_ok, output bit tmo);
    int k;
    tmo = 0; en_cnt = 0; addr_ok = 1; lat = -1; k = 0;
    while (!in_ready && k < 50) begin @(posedge CLK); #1; k++; end
    if (!in_ready) begin tmo = 1; return; end
    in_valid = 1; in_acc = acc; in_addr = addr;
    cfg_scale = sc; cfg_shift = sh; cfg_zp = zp; cfg_relu = relu;
    @(posedge CLK); #1;
    in_valid = 0; in_acc = {8{$urandom}}; in_addr = 12'($urandom);
    cfg_scale = 16'($urandom); cfg_shift = 5'($urandom); cfg_zp = 8'($urandom); cfg_relu = 1'($urandom);
    for (k = 0; k < 20; k++) begin
      if (out_valid) begin lat = k; break; end
      if (bias_en) begin en_cnt++; if (bias_addr !== addr) addr_ok = 0; end
      @(posedge CLK); #1;
    end
    if (lat < 0) tmo = 1;
  endtask

  task automatic handshake();
    out_ready = 1;
    @(posedge CLK); #1;
    out_ready = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (out_valid !== 0 || bias_en !== 0 || busy !== 0) begin
      errors++; $display("FAIL reset_ctrl got vld=%b en=%b busy=%b exp 0 0 0", out_valid, bias_en, busy);
    end
    checks++;
    if (bias_addr !== 12'd0) begin errors++; $display("FAIL reset_addr got=%h exp=0", bias_addr); end
    checks++;
    if (out_data !== 64'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", out_data); end
    RST = 0;
    @(posedge CLK); #1;
    checks++;
    if (in_ready !== 1 || busy !== 0) begin
      errors++; $display("FAIL reset_release got rdy=%b busy=%b exp 1 0", in_ready, busy);
    end
  endtask

  task automatic test_basic();
    int lat, en; bit aok, tmo;
    logic [11:0] addr;
    addr = 12'($urandom_range(1, 4088));
    for (int i = 0; i < LANES; i++) mem[addr + i] = -4;
    run_vec({8{32'd100}}, addr, 16'd3, 5'd2, 8'd0, 1'b0, lat, en, aok, tmo);
    checks++;
    if (tmo || lat !== 4) begin errors++; $display("FAIL basic_latency got=%0d exp=4", lat); end
    checks++;
    if (en !== 1) begin errors++; $display("FAIL basic_bias_en_cycles got=%0d exp=1", en); end
    checks++;
    if (!aok) begin errors++; $display("FAIL basic_bias_addr got=%h exp=%h", bias_addr, addr); end
    checks++;
    if (out_data !== {8{8'd72}}) begin errors++; $display("FAIL basic_data got=%h exp=%h", out_data, {8{8'd72}}); end
    handshake();
    checks++;
    if (out_valid !== 0 || in_ready !== 1) begin
      errors++; $display("FAIL basic_handshake got vld=%b rdy=%b exp 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_clamp_round();
    int ta [3] = '{1000, -5, -2000};
    int tbias [3] = '{24, 0, 0};
    logic [4:0] tsh [3] = '{5'd3, 5'd1, 5'd0};
    logic [7:0] tex [3] = '{8'd127, 8'hFE, 8'h80};
    int lat, en; bit aok, tmo;
    logic [11:0] addr; logic [255:0] acc; logic [63:0] ex;
    for (int v = 0; v < 3; v++) begin
      addr = 12'($urandom_range(0, 4088));
      for (int i = 0; i < LANES; i++) begin
        mem[addr + i] = $urandom_range(0, 400) - 200;
        acc[32*i +: 32] = 32'($urandom_range(0, 4000)) - 32'd2000;
      end
      mem[addr + v] = tbias[v];
      acc[32*v +: 32] = ta[v];
      ex = exp_vec(acc, int'(addr), 16'd1, tsh[v], 8'd0, 1'b0);
      run_vec(acc, addr, 16'd1, tsh[v], 8'd0, 1'b0, lat, en, aok, tmo);
      checks++;
      if (tmo || out_data[8*v +: 8] !== tex[v]) begin
        errors++; $display("FAIL clamp_round_lane%0d got=%h exp=%h", v, out_data[8*v +: 8], tex[v]);
      end
      checks++;
      if (out_data !== ex) begin errors++; $display("FAIL clamp_round_vec%0d got=%h exp=%h", v, out_data, ex); end
      handshake();
    end
  endtask

  task automatic test_saturation();
    logic [31:0] sa [2] = '{32'h7FFF_FFF0, 32'h8000_0010};
    logic [31:0] sb [2] = '{32'h0000_0100, 32'hFFFF_FF00};
    logic [7:0]  se [2] = '{8'd127, 8'h80};
    int lat, en; bit aok, tmo;
    logic [11:0] addr;
    for (int v = 0; v < 2; v++) begin
      addr = 12'($urandom_range(0, 4088));
      for (int i = 0; i < LANES; i++) mem[addr + i] = int'(sb[v]);
      run_vec({8{sa[v]}}, addr, 16'd1, 5'd24, 8'd0, 1'b0, lat, en, aok, tmo);
      checks++;
      if (tmo || out_data !== {8{se[v]}}) begin
        errors++; $display("FAIL saturation%0d got=%h exp=%h", v, out_data, {8{se[v]}});
      end
      handshake();
    end
  endtask

  task automatic test_relu_zp();
    int ra [3] = '{-50, -50, 200};
    logic rr [3] = '{1'b1, 1'b0, 1'b0};
    logic [7:0] re [3] = '{8'd5, 8'hD3, 8'd127};
    int lat, en; bit aok, tmo;
    logic [11:0] addr;
    for (int v = 0; v < 3; v++) begin
      addr = 12'($urandom_range(0, 4088));
      for (int i = 0; i < LANES; i++) mem[addr + i] = 0;
      run_vec({8{ra[v]}}, addr, 16'd1, 5'd0, 8'd5, rr[v], lat, en, aok, tmo);
      checks++;
      if (tmo || out_data !== {8{re[v]}}) begin
        errors++; $display("FAIL relu_zp%0d got=%h exp=%h", v, out_data, {8{re[v]}});
      end
      handshake();
    end
  endtask

  task automatic test_random();
    int lat, en; bit aok, tmo;
    logic [11:0] addr; logic [255:0] acc; logic [63:0] ex;
    logic [15:0] sc; logic [4:0] sh; logic [7:0] zp; logic relu;
    for (int n = 0; n < 20; n++) begin
      addr = 12'($urandom_range(0, 4088));
      for (int i = 0; i < LANES; i++) begin
        mem[addr + i] = ($urandom_range(0, 3) == 0) ? int'($urandom) : $urandom_range(0, 20000) - 10000;
        acc[32*i +: 32] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 200000)) - 32'd100000;
      end
      sc = 16'($urandom); sh = 5'($urandom_range(8, 31)); zp = 8'($urandom); relu = 1'($urandom);
      ex = exp_vec(acc, int'(addr), sc, sh, zp, relu);
      run_vec(acc, addr, sc, sh, zp, relu, lat, en, aok, tmo);
      checks++;
      if (tmo || lat !== 4 || out_data !== ex) begin
        errors++; $display("FAIL random%0d got=%h lat=%0d exp=%h lat=4", n, out_data, lat, ex);
      end
      handshake();
    end
  endtask

  task automatic test_backpressure();
    int lat, en, k; bit aok, tmo;
    logic [11:0] addr, addr_b; logic [255:0] acc, acc_b; logic [63:0] ex, ex_b;
    addr = 12'($urandom_range(1, 2000));
    addr_b = 12'($urandom_range(2100, 4088));
    for (int i = 0; i < LANES; i++) begin
      mem[addr + i] = $urandom_range(0, 200) - 100;
      mem[addr_b + i] = $urandom_range(0, 200) - 100;
      acc[32*i +: 32] = 32'($urandom_range(0, 2000)) - 32'd1000;
      acc_b[32*i +: 32] = 32'($urandom_range(0, 2000)) - 32'd1000;
    end
    ex = exp_vec(acc, int'(addr), 16'd5, 5'd3, 8'hF0, 1'b0);
    ex_b = exp_vec(acc_b, int'(addr_b), 16'd7, 5'd4, 8'd3, 1'b1);
    run_vec(acc, addr, 16'd5, 5'd3, 8'hF0, 1'b0, lat, en, aok, tmo);
    in_valid = 1; in_acc = acc_b; in_addr = addr_b;
    cfg_scale = 16'd7; cfg_shift = 5'd4; cfg_zp = 8'd3; cfg_relu = 1'b1;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (tmo || out_valid !== 1 || out_data !== ex || in_ready !== 0) begin
        errors++; $display("FAIL backpressure_hold%0d got vld=%b rdy=%b data=%h exp 1 0 %h",
                            c, out_valid, in_ready, out_data, ex);
      end
      @(posedge CLK); #1;
    end
    handshake();
    checks++;
    if (out_valid !== 0 || in_ready !== 1) begin
      errors++; $display("FAIL backpressure_release got vld=%b rdy=%b exp 0 1", out_valid, in_ready);
    end
    @(posedge CLK); #1;
    in_valid = 0; cfg_scale = 16'($urandom); cfg_zp = 8'($urandom);
    lat = -1;
    for (k = 0; k < 20; k++) begin
      if (out_valid) begin lat = k; break; end
      @(posedge CLK); #1;
    end
    checks++;
    if (lat !== 4 || out_data !== ex_b) begin
      errors++; $display("FAIL backpressure_second got=%h lat=%0d exp=%h lat=4", out_data, lat, ex_b);
    end
    handshake();
  endtask

  task automatic test_reset_mid();
    int lat, en, seen; bit aok, tmo;
    logic [11:0] addr; logic [255:0] acc; logic [63:0] ex;
    addr = 12'($urandom_range(1, 4088));
    for (int i = 0; i < LANES; i++) mem[addr + i] = 10;
    in_valid = 1; in_acc = {8{32'd500}}; in_addr = addr;
    cfg_scale = 16'd1; cfg_shift = 5'd2; cfg_zp = 8'd0; cfg_relu = 1'b0;
    @(posedge CLK); #1;
    in_valid = 0;
    repeat (2) begin @(posedge CLK); #1; end
    checks++;
    if (busy !== 1) begin errors++; $display("FAIL reset_mid_busy got=%b exp=1", busy); end
    RST = 1;
    #1;
    checks++;
    if (out_valid !== 0 || bias_en !== 0 || busy !== 0 || bias_addr !== 12'd0 || out_data !== 64'd0) begin
      errors++; $display("FAIL reset_mid_async got vld=%b en=%b busy=%b addr=%h data=%h exp all 0",
                          out_valid, bias_en, busy, bias_addr, out_data);
    end
    @(posedge CLK); #1;
    RST = 0;
    seen = 0;
    repeat (6) begin @(posedge CLK); #1; if (out_valid) seen++; end
    checks++;
    if (seen !== 0 || in_ready !== 1) begin
      errors++; $display("FAIL reset_mid_stale got vld_cycles=%0d rdy=%b exp 0 1", seen, in_ready);
    end
    addr = 12'($urandom_range(0, 4088));
    for (int i = 0; i < LANES; i++) begin
      mem[addr + i] = $urandom_range(0, 100) - 50;
      acc[32*i +: 32] = 32'($urandom_range(0, 600)) - 32'd300;
    end
    ex = exp_vec(acc, int'(addr), 16'd9, 5'd3, 8'd2, 1'b0);
    run_vec(acc, addr, 16'd9, 5'd3, 8'd2, 1'b0, lat, en, aok, tmo);
    checks++;
    if (tmo || lat !== 4 || out_data !== ex) begin
      errors++; $display("FAIL reset_mid_next got=%h lat=%0d exp=%h lat=4", out_data, lat, ex);
    end
    handshake();
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = $urandom_range(0, 2000) - 1000;
    test_reset();
    test_basic();
    test_clamp_round();
    test_saturation();
    test_relu_zp();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
